// File: rtl/viterbi_decision_out.sv
// viterbi_decision_out
// Final decision stage of the Viterbi decoder. Captures the four path metrics
// and survivor words when the ACS chain completes a frame, picks the survivor
// with the smallest metric, queues the decoded byte in a small output FIFO
// with a valid/ready handshake, and pulses renew to clear the ACS pipeline.

module viterbi_decision_out #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [2:0] FINAL_PTR  = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [2:0]  write_pointer_in,
    input  logic [3:0]  metric_00,
    input  logic [3:0]  metric_01,
    input  logic [3:0]  metric_10,
    input  logic [3:0]  metric_11,
    input  logic [7:0]  path_00,
    input  logic [7:0]  path_01,
    input  logic [7:0]  path_10,
    input  logic [7:0]  path_11,
    output logic        renew,
    output logic [7:0]  data_out,
    output logic [3:0]  metric_out,
    output logic [1:0]  state_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [15:0] frame_count,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_WAIT,
        S_SELECT,
        S_RENEW
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] metric;
        logic [1:0] state;
    } entry_t;

    state_t        state;
    logic [3:0]    cap_metric [4];
    logic [7:0]    cap_path   [4];

    logic [3:0]    best_metric;
    logic [1:0]    best_state;

    entry_t        mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          push_ok;
    logic          frame_seen;

    assign frame_seen = valid_in && (write_pointer_in == FINAL_PTR);
    assign data_valid = (count != '0);
    assign pop        = data_valid && data_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign push_ok    = (state == S_SELECT) && ((count < CW'(FIFO_DEPTH)) || pop);

    // Minimum-metric search over the captured metrics; strict compare keeps the lowest index on ties.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        best_metric = cap_metric[0];
        best_state  = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cap_metric[i] < best_metric) begin
                best_metric = cap_metric[i];
                best_state  = 2'(i);
            end
        end
    end

    // Frame FSM: capture, select/push, renew pulse, plus frame counter and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state       <= S_WAIT;
            renew       <= 1'b0;
            frame_count <= '0;
            overflow    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cap_metric[i] <= '0;
                cap_path[i]   <= '0;
            end
        end else begin
            case (state)
                S_WAIT: begin
                    renew <= 1'b0;
                    if (frame_seen) begin
                        cap_metric[0] <= metric_00;
                        cap_metric[1] <= metric_01;
                        cap_metric[2] <= metric_10;
                        cap_metric[3] <= metric_11;
                        cap_path[0]   <= path_00;
                        cap_path[1]   <= path_01;
                        cap_path[2]   <= path_10;
                        cap_path[3]   <= path_11;
                        state         <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (push_ok) begin
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                    renew <= 1'b1;
                    state <= S_RENEW;
                end
                S_RENEW: begin
                    renew <= 1'b0;
                    state <= S_WAIT;
                end
                default: begin
                    renew <= 1'b0;
                    state <= S_WAIT;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write; the winning survivor is taken straight from the select logic.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; empty entries are never visible because the head is gated by data_valid.
        if (push_ok) begin
            mem[wr_ptr] <= '{data: cap_path[best_state], metric: best_metric, state: best_state};
        end
    end

    assign data_out   = data_valid ? mem[rd_ptr].data   : 8'd0;
    assign metric_out = data_valid ? mem[rd_ptr].metric : 4'd0;
    assign state_out  = data_valid ? mem[rd_ptr].state  : 2'd0;

endmodule

// File: doc/viterbi_decision_out.md
# viterbi_decision_out

Final decision and output stage of the Viterbi decoder, directly downstream of the ACS chain. When the last ACS stage reports a completed 8-bit frame, this block captures the four path metrics and survivor words and selects the survivor with the smallest metric. It buffers the decoded byte in a small FIFO with a valid/ready output handshake, then pulses `renew` to clear the ACS pipeline for the next frame.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; must be a power of two, at least 2.
- `FINAL_PTR`, default 3'd0: `write_pointer_in` value that marks a completed frame. The ACS 3-bit pointer wraps to 0 after the eighth bit.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `valid_in` input 1: ACS outputs valid this cycle.
- `write_pointer_in` input 3: ACS write pointer.
- `metric_00`, `metric_01`, `metric_10`, `metric_11` input 4 each: path metrics per state.
- `path_00`, `path_01`, `path_10`, `path_11` input 8 each: survivor words per state; bit 7 is the oldest decoded bit.
- `renew` output 1: one-cycle pulse that clears the ACS stages.
- `data_out` output 8: decoded byte at the FIFO head.
- `metric_out` output 4: winning metric at the FIFO head.
- `state_out` output 2: winning state at the FIFO head.
- `data_valid` output 1: FIFO non-empty.
- `data_ready` input 1: downstream accepts the head this cycle.
- `frame_count` output 16: frames pushed into the FIFO.
- `overflow` output 1: sticky flag; set when a frame is dropped because the FIFO is full.

## Operation
- FSM states: `S_WAIT`, `S_SELECT`, `S_RENEW`. Reset state is `S_WAIT`.
- `S_WAIT`
  - If `valid_in` is high and `write_pointer_in == FINAL_PTR`, register all four metrics and paths, then go to `S_SELECT`.
  - Otherwise stay in `S_WAIT`.
  - `valid_in` is ignored in every other state.
- `S_SELECT`
  - Select the minimum registered metric with an unsigned compare.
  - Ties resolve to the lowest state index: 00 < 01 < 10 < 11.
  - Push {path, metric, state} into the FIFO, then go to `S_RENEW`.
- Push acceptance:
  - Accepted if FIFO count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the frame is dropped, `overflow` is set to 1, and `frame_count` is unchanged.
  - In both cases the FSM proceeds to `S_RENEW`.
- `S_RENEW`: `renew` is high for exactly this one cycle, then go to `S_WAIT`.
- FIFO
  - Head drives `data_out`, `metric_out` and `state_out`; `data_valid` = count != 0.
  - A pop occurs when `data_valid && data_ready`.
  - Read and write pointers wrap modulo `FIFO_DEPTH`.
  - Head outputs hold their value while `data_ready` is low.
- `frame_count` increments by 1 on each accepted push and wraps from 16'hFFFF to 0.
- `overflow` is cleared only by reset.
- Reset (`rst_n` low, asynchronous, including mid-frame or mid-handshake):
  - FSM returns to `S_WAIT` and the FIFO is emptied.
  - `renew`=0, `data_valid`=0, `data_out`=0, `metric_out`=0, `state_out`=0, `frame_count`=0, `overflow`=0.
  - A captured frame that was not yet pushed is discarded.

## Timing
- Edge E0: capture (frame condition seen in `S_WAIT`).
- Edge E1: FIFO push; `data_valid` rises after E1 if the FIFO was empty; `renew` is high during the cycle after E1.
- Edge E2: FSM returns to `S_WAIT`.
- Latency: 2 cycles from capture to `data_valid`; minimum frame-to-frame spacing is 3 cycles.
- `renew` is registered and glitch-free. Upstream clears on the edge ending the `renew` cycle, so no frame condition can appear during `S_SELECT` or `S_RENEW`.
- Simultaneous push and pop with the FIFO full: both occur, count is unchanged, and no overflow is flagged.
- Simultaneous push and pop with the FIFO empty: the pop is impossible because `data_valid`=0, so only the push occurs.
- Output handshake is standard valid/ready: while `data_valid` is high and `data_ready` is low, `data_valid` stays high and the head outputs stay stable.

## Test plan
- Reset check: hold `rst_n`=0, then release.
  - Every output is 0 and no `renew` occurs.
  - Apply `valid_in`=1 with `write_pointer_in`=5: no capture.
- Basic decode: metrics 00=5, 01=2, 10=7, 11=3; paths 8'hA5, 8'h3C, 8'hFF, 8'h00; `write_pointer_in`=0; `data_ready`=1.
  - Two cycles later: `data_out`=8'h3C, `metric_out`=2, `state_out`=01, `data_valid` high for 1 cycle.
  - `renew` pulses once; `frame_count`=1.
- Tie break: all four metrics = 4.
  - Output `state_out`=00 with the path_00 value.
- Back-pressure and overflow: `data_ready`=0; send 5 frames spaced 3 cycles apart.
  - FIFO holds frames 1-4 in order; `overflow`=1 after frame 5; `frame_count`=4; `renew` pulsed 5 times.
  - Then raise `data_ready`: frames 1-4 drain in order.
- Full FIFO with simultaneous pop: with the FIFO full, `data_ready`=1 in the push cycle.
  - Push accepted, count stays 4, `overflow` stays 0.
- Reset mid-frame: assert `rst_n`=0 during `S_SELECT`.
  - FIFO is empty, no `renew`, `frame_count`=0.
  - The next frame decodes normally.
